// File: rtl/jpeg_pkg.sv
// Shared JPEG front-end definitions: pixel geometry, the YCbCr pixel
// record and the level-shift helper used ahead of the DCT.
package jpeg_pkg;

  localparam int PIX_W      = 8;
  localparam int BLK_DIM    = 8;
  localparam int BLK_PIXELS = BLK_DIM * BLK_DIM;
  localparam int ADDR_W     = $clog2(BLK_PIXELS);

  typedef struct packed {
    logic [PIX_W-1:0] cr;
    logic [PIX_W-1:0] cb;
    logic [PIX_W-1:0] y;
  } ycbcr_pix_t;

  // x - 2^(PIX_W-1) on an unsigned PIX_W-bit value is just an MSB flip
  // and lands exactly in the signed range, so no saturation is needed.
  function automatic ycbcr_pix_t level_shift(input ycbcr_pix_t p);
    ycbcr_pix_t r;
    r = p;
    r.cr[PIX_W-1] = ~p.cr[PIX_W-1];
    r.cb[PIX_W-1] = ~p.cb[PIX_W-1];
    r.y[PIX_W-1]  = ~p.y[PIX_W-1];
    return r;
  endfunction

endpackage

// File: rtl/block_bank_ram.sv
// Two banks of one 8x8 block each: synchronous write, combinational read.
module block_bank_ram
  import jpeg_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic              wr_bank_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  ycbcr_pix_t        wr_data_i,
  input  logic              rd_bank_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output ycbcr_pix_t        rd_data_o
);

  ycbcr_pix_t mem_q [2*BLK_PIXELS];

  // Pixel store; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[{rd_bank_i, rd_addr_i}];

endmodule

// File: rtl/ycbcr_block_buffer.sv
// Ping-pong 8x8 block buffer between colour conversion and the DCT.
// Raster-order pixels fill one bank while the other is streamed out,
// level-shifted, in row- or column-major order.
module ycbcr_block_buffer #(
  parameter int PIX_W     = jpeg_pkg::PIX_W,
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [3*PIX_W-1:0] data_in,
  output logic               in_ready,
  output logic [3*PIX_W-1:0] data_out,
  output logic               enable_out,
  input  logic               out_ready,
  output logic               block_start,
  output logic               block_end,
  output logic               overflow
);
  import jpeg_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BLK_PIXELS - 1);

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              ovf_q, ovf_d;
  ycbcr_pix_t        dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              bs_q, bs_d;
  logic              be_q, be_d;

  ycbcr_pix_t        pix_in;
  ycbcr_pix_t        rd_pix;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic              adv;

  assign pix_in   = data_in;
  assign in_ready = ~full_q[wr_bank_q];
  assign wr_en    = enable & in_ready;
  assign adv      = ~vld_q | out_ready;

  // Column-major read swaps the row and column halves of the counter.
  assign rd_addr  = TRANSPOSE ? {rd_cnt_q[2:0], rd_cnt_q[5:3]} : rd_cnt_q;

  block_bank_ram u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (pix_in),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_pix)
  );

  // Next state for both bank sides; the set and clear of full always
  // target different banks, so applying them in sequence is safe.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    ovf_d     = ovf_q | (enable & ~in_ready);
    dout_d    = dout_q;
    vld_d     = vld_q;
    bs_d      = bs_q;
    be_d      = be_q;

    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    if (adv) begin
      if (full_q[rd_bank_q]) begin
        dout_d   = level_shift(rd_pix);
        vld_d    = 1'b1;
        bs_d     = (rd_cnt_q == '0);
        be_d     = (rd_cnt_q == LAST);
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
        end
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  // State registers; reset drops any partial or pending block.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      bs_q      <= 1'b0;
      be_q      <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      ovf_q     <= ovf_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      bs_q      <= bs_d;
      be_q      <= be_d;
    end
  end

  assign data_out    = dout_q;
  assign enable_out  = vld_q;
  assign block_start = bs_q;
  assign block_end   = be_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ycbcr_block_buffer.sv
// Directed bench: a row-major and a column-major instance share stimulus.
module tb_ycbcr_block_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] data_in = '0;
  logic        out_ready = 1'b0;

  logic        in_ready0, enable_out0, bs0, be0, ovf0;
  logic [23:0] data_out0;
  logic        in_ready1, enable_out1, bs1, be1, ovf1;
  logic [23:0] data_out1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ycbcr_block_buffer #(.PIX_W(8), .TRANSPOSE(1'b0)) u_row (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
    .in_ready(in_ready0), .data_out(data_out0), .enable_out(enable_out0),
    .out_ready(out_ready), .block_start(bs0), .block_end(be0), .overflow(ovf0)
  );

  ycbcr_block_buffer #(.PIX_W(8), .TRANSPOSE(1'b1)) u_col (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in),
    .in_ready(in_ready1), .data_out(data_out1), .enable_out(enable_out1),
    .out_ready(out_ready), .block_start(bs1), .block_end(be1), .overflow(ovf1)
  );

  // One-cycle reset; entered and left at a falling edge.
  task automatic do_reset;
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; enable = 1'b1; data_in = 24'h123456; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
    checks++; if (enable_out0 !== 1'b0) begin errors++; $display("FAIL reset_enable_out: got %b want 0", enable_out0); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", ovf0); end
    checks++; if (data_out0 !== 24'h0) begin errors++; $display("FAIL reset_data_out: got %h want 000000", data_out0); end
    checks++; if ({bs0, be0} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {bs0, be0}); end
    checks++; if (enable_out1 !== 1'b0) begin errors++; $display("FAIL reset_enable_out_col: got %b want 0", enable_out1); end
    rst = 1'b0; enable = 1'b0;
  endtask

  task automatic test_single_block;
    int nin, nout, first;
    logic [23:0] exp;
    nin = 0; nout = 0; first = -1;
    do_reset;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (enable_out0 && out_ready) begin
        if (nout == 0) first = cyc;
        exp = {8'h7F, 8'h00, 8'(2*nout - 128)};
        checks++;
        if (data_out0 !== exp || bs0 !== (nout == 0) || be0 !== (nout == 63)) begin
          errors++;
          $display("FAIL single_block pix %0d: got data=%h start=%b end=%b, want data=%h start=%b end=%b",
                   nout, data_out0, bs0, be0, exp, (nout == 0), (nout == 63));
        end
        nout++;
      end
      if (nin < 64) begin
        enable = 1'b1; data_in = {8'd255, 8'd128, 8'(2*nin)}; nin++;
      end else begin
        enable = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (nout != 64) begin errors++; $display("FAIL single_block_count: got %0d want 64", nout); end
    checks++; if (first != 65) begin errors++; $display("FAIL single_block_latency: first output at cycle %0d want 65", first); end
  endtask

  task automatic test_transpose;
    int nin, nout;
    logic [23:0] exp;
    nin = 0; nout = 0;
    do_reset;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (enable_out1 && out_ready) begin
        exp = {8'h00, 8'h00, 8'(((nout % 8) * 8 + nout / 8) - 128)};
        checks++;
        if (data_out1 !== exp || bs1 !== (nout == 0) || be1 !== (nout == 63)) begin
          errors++;
          $display("FAIL transpose pix %0d: got data=%h start=%b end=%b, want data=%h",
                   nout, data_out1, bs1, be1, exp);
        end
        nout++;
      end
      if (nin < 64) begin
        enable = 1'b1; data_in = {8'd128, 8'd128, 8'(nin)}; nin++;
      end else begin
        enable = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (nout != 64) begin errors++; $display("FAIL transpose_count: got %0d want 64", nout); end
  endtask

  task automatic test_backpressure;
    int nout;
    logic [23:0] exp;
    nout = 0;
    do_reset;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 130; cyc++) begin
      if (cyc == 127) begin
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL bp_in_ready_127: got %b want 1", in_ready0); end
      end
      if (cyc == 128) begin
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL bp_in_ready_128: got %b want 0", in_ready0); end
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL bp_overflow_early: got %b want 0", ovf0); end
      end
      if (cyc == 129) begin
        checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL bp_overflow_set: got %b want 1", ovf0); end
        checks++; if (enable_out0 !== 1'b1 || data_out0 !== 24'h000080) begin
          errors++; $display("FAIL bp_held_output: got vld=%b data=%h want vld=1 data=000080", enable_out0, data_out0);
        end
      end
      if (cyc < 129) begin
        enable = 1'b1; data_in = {8'd128, 8'd128, 8'(cyc)};
      end else begin
        enable = 1'b0;
      end
      @(negedge clk);
    end
    enable = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (enable_out0 && out_ready) begin
        exp = {8'h00, 8'h00, 8'(nout - 128)};
        checks++;
        if (data_out0 !== exp) begin
          errors++; $display("FAIL bp_drain pix %0d: got %h want %h", nout, data_out0, exp);
        end
        nout++;
      end
      @(negedge clk);
    end
    checks++; if (nout != 128) begin errors++; $display("FAIL bp_drain_count: got %0d want 128", nout); end
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky: got %b want 1", ovf0); end
  endtask

  task automatic test_mid_block_reset;
    int nout, early;
    nout = 0; early = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (enable_out0) early++;
      enable = 1'b1; data_in = {8'd128, 8'd128, 8'd50};
      @(negedge clk);
    end
    enable = 1'b0;
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL mid_overflow_before_rst: got %b want 1", ovf0); end
    do_reset;
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL mid_overflow_after_rst: got %b want 0", ovf0); end
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (enable_out0 && out_ready) begin
        checks++;
        if (data_out0 !== 24'h0000E4) begin
          errors++; $display("FAIL mid_reset pix %0d: got %h want 0000e4", nout, data_out0);
        end
        nout++;
      end
      if (cyc < 64) begin
        enable = 1'b1; data_in = {8'd128, 8'd128, 8'd100};
      end else begin
        enable = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (early != 0) begin errors++; $display("FAIL mid_early_output: got %0d outputs want 0", early); end
    checks++; if (nout != 64) begin errors++; $display("FAIL mid_reset_count: got %0d want 64", nout); end
  endtask

  task automatic test_back_to_back;
    int nin, nout, first, last, drops;
    logic [23:0] exp;
    nin = 0; nout = 0; first = -1; last = -1; drops = 0;
    do_reset;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 320; cyc++) begin
      if (enable_out0 && out_ready) begin
        if (nout == 0) first = cyc;
        last = cyc;
        exp = {8'h00, 8'h00, 8'(nout - 128)};
        checks++;
        if (data_out0 !== exp) begin
          errors++; $display("FAIL stream pix %0d: got %h want %h", nout, data_out0, exp);
        end
        nout++;
      end
      if (nin < 192) begin
        if (in_ready0 !== 1'b1) drops++;
        enable = 1'b1; data_in = {8'd128, 8'd128, 8'(nin)}; nin++;
      end else begin
        enable = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (drops != 0) begin errors++; $display("FAIL stream_in_ready: %0d cycles low want 0", drops); end
    checks++; if (nout != 192) begin errors++; $display("FAIL stream_count: got %0d want 192", nout); end
    checks++; if (last - first != 191) begin errors++; $display("FAIL stream_gapless: span %0d want 191", last - first); end
    checks++; if (first != 65) begin errors++; $display("FAIL stream_latency: got %0d want 65", first); end
  endtask

  initial begin
    test_reset;
    test_single_block;
    test_transpose;
    test_backpressure;
    test_mid_block_reset;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
